// File: rtl/retire_trace_buffer.sv
// Retirement trace buffer: logs register (and optionally memory) writes with PC and timestamp.
// Define TRACE_MEM_EN to also capture data-memory stores as type-1 entries.
module retire_trace_buffer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned MODE   = 0,
    parameter int unsigned TS_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [DATA_W-1:0]        pc,
    input  logic                     reg_we,
    input  logic [4:0]               reg_addr,
    input  logic [DATA_W-1:0]        reg_wdata,
    input  logic                     mem_we,
    input  logic [DATA_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_type,
    output logic [TS_W-1:0]          out_ts,
    output logic [DATA_W-1:0]        out_pc,
    output logic [DATA_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [15:0]              drop_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              typ;
        logic [TS_W-1:0]   ts;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             store_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [15:0]        drop_q, drop_d;
    logic [TS_W-1:0]    ts_q;

    logic   reg_ev, mem_ev, push_req, pop, is_full, do_write, overwrite;
    logic [1:0]  lost;
    logic [16:0] drop_sum;
    entry_t push_entry, head_entry;

`ifdef TRACE_MEM_EN
    assign mem_ev = en && mem_we;
`else
    logic unused_mem;
    assign unused_mem = ^{mem_we, mem_addr, mem_wdata};
    assign mem_ev     = 1'b0;
`endif

    always_comb begin
        reg_ev   = en && reg_we && (reg_addr != 5'd0);
        push_req = reg_ev || mem_ev;
        pop      = (count_q != '0) && out_ready;
        is_full  = (count_q == CNT_W'(DEPTH));

        // A register write wins a same-cycle collision with a store.
        push_entry = '0;
        if (reg_ev) begin
            push_entry.typ  = 1'b0;
            push_entry.ts   = ts_q;
            push_entry.pc   = pc;
            push_entry.addr = DATA_W'(reg_addr);
            push_entry.data = reg_wdata;
        end else if (mem_ev) begin
            push_entry.typ  = 1'b1;
            push_entry.ts   = ts_q;
            push_entry.pc   = pc;
            push_entry.addr = mem_addr;
            push_entry.data = mem_wdata;
        end

        overwrite = push_req && is_full && !pop && (MODE == 1);
        do_write  = push_req && (!is_full || pop || (MODE == 1));
        lost      = 2'(reg_ev && mem_ev) + 2'(push_req && is_full && !pop);

        head_d = head_q + PTR_W'(pop || overwrite);
        tail_d = tail_q + PTR_W'(do_write);

        count_d = count_q;
        if (do_write && !pop && !overwrite) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !do_write) begin
            count_d = count_q - CNT_W'(1);
        end

        drop_sum = {1'b0, drop_q} + 17'(lost);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= '0;
            ts_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            ts_q    <= ts_q + TS_W'(1);
        end
    end

    // Entry storage is never reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_write) begin
            store_q[tail_q] <= push_entry;
        end
    end

    always_comb begin
        head_entry = store_q[head_q];
        out_valid  = (count_q != '0);
        if (!out_valid) begin
            head_entry = '0;
        end
        out_type = head_entry.typ;
        out_ts   = head_entry.ts;
        out_pc   = head_entry.pc;
        out_addr = head_entry.addr;
        out_data = head_entry.data;
        count    = count_q;
        full     = is_full;
        empty    = (count_q == '0);
        drop_cnt = drop_q;
    end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Randomized bench for retire_trace_buffer: DEPTH 4 instances in both full policies vs a queue model.
module tb_retire_trace_buffer;

    localparam int DW = 32;
    localparam int D  = 4;
    localparam int TW = 16;

    typedef struct packed {
        logic          typ;
        logic [TW-1:0] ts;
        logic [DW-1:0] pc;
        logic [DW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    logic en, reg_we, mem_we, out_ready;
    logic [4:0]    reg_addr;
    logic [DW-1:0] pc, reg_wdata, mem_addr, mem_wdata;

    logic          o_valid [2];
    logic          o_type  [2];
    logic          o_full  [2];
    logic          o_empty [2];
    logic [TW-1:0] o_ts    [2];
    logic [DW-1:0] o_pc    [2];
    logic [DW-1:0] o_addr  [2];
    logic [DW-1:0] o_data  [2];
    logic [2:0]    o_count [2];
    logic [15:0]   o_drop  [2];

    ent_t          mq [2][$];
    int            md [2];
    logic [TW-1:0] mts;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        retire_trace_buffer #(
            .DATA_W(DW), .DEPTH(D), .MODE(g), .TS_W(TW)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .en        (en),
            .pc        (pc),
            .reg_we    (reg_we),
            .reg_addr  (reg_addr),
            .reg_wdata (reg_wdata),
            .mem_we    (mem_we),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .out_valid (o_valid[g]),
            .out_ready (out_ready),
            .out_type  (o_type[g]),
            .out_ts    (o_ts[g]),
            .out_pc    (o_pc[g]),
            .out_addr  (o_addr[g]),
            .out_data  (o_data[g]),
            .count     (o_count[g]),
            .full      (o_full[g]),
            .empty     (o_empty[g]),
            .drop_cnt  (o_drop[g])
        );
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        ent_t h;
        for (int i = 0; i < 2; i++) begin
            h = (mq[i].size() > 0) ? mq[i][0] : '0;
            check_val($sformatf("u%0d.valid", i), 64'(o_valid[i]), 64'(mq[i].size() > 0));
            check_val($sformatf("u%0d.count", i), 64'(o_count[i]), 64'(mq[i].size()));
            check_val($sformatf("u%0d.full", i),  64'(o_full[i]),  64'(mq[i].size() == D));
            check_val($sformatf("u%0d.empty", i), 64'(o_empty[i]), 64'(mq[i].size() == 0));
            check_val($sformatf("u%0d.drop", i),  64'(o_drop[i]),  64'(md[i]));
            check_val($sformatf("u%0d.type", i),  64'(o_type[i]),  64'(h.typ));
            check_val($sformatf("u%0d.ts", i),    64'(o_ts[i]),    64'(h.ts));
            check_val($sformatf("u%0d.pc", i),    64'(o_pc[i]),    64'(h.pc));
            check_val($sformatf("u%0d.addr", i),  64'(o_addr[i]),  64'(h.addr));
            check_val($sformatf("u%0d.data", i),  64'(o_data[i]),  64'(h.data));
        end
    endtask

    // Instance 0 drops the newest event when full; instance 1 evicts the oldest.
    task automatic model_edge();
        ent_t e;
        bit   rev, mev, have;
        int   lost;
        rev = en && reg_we && (reg_addr != 0);
`ifdef TRACE_MEM_EN
        mev = en && mem_we;
`else
        mev = 1'b0;
`endif
        have = rev || mev;
        if (rev) e = '{typ: 1'b0, ts: mts, pc: pc, addr: DW'(reg_addr), data: reg_wdata};
        else     e = '{typ: 1'b1, ts: mts, pc: pc, addr: mem_addr, data: mem_wdata};
        for (int i = 0; i < 2; i++) begin
            lost = (rev && mev) ? 1 : 0;
            if (mq[i].size() > 0 && out_ready) void'(mq[i].pop_front());
            if (have) begin
                if (mq[i].size() < D) begin
                    mq[i].push_back(e);
                end else begin
                    lost++;
                    if (i == 1) begin
                        void'(mq[i].pop_front());
                        mq[i].push_back(e);
                    end
                end
            end
            md[i] = (md[i] + lost > 65535) ? 65535 : md[i] + lost;
        end
        mts++;
    endtask

    task automatic step(input logic r_we, input logic [4:0] ra, input logic [DW-1:0] rd,
                        input logic [DW-1:0] p, input logic m_we, input logic [DW-1:0] ma,
                        input logic [DW-1:0] mdat, input logic rdy);
        reg_we    = r_we;
        reg_addr  = ra;
        reg_wdata = rd;
        pc        = p;
        mem_we    = m_we;
        mem_addr  = ma;
        mem_wdata = mdat;
        out_ready = rdy;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en = 1'b1; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0; pc = '0;
        mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            md[i] = 0;
        end
        mts = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        compare_all();
    endtask

    initial begin
        logic rdy;
        do_reset();

        // addi $1,$0,5 retiring at ts 3 with pc 0x8
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5, 32'h8, 0, 0, 0, 0);
        check_val("addi.valid", 64'(o_valid[0]), 64'd1);
        check_val("addi.type",  64'(o_type[0]),  64'd0);
        check_val("addi.addr",  64'(o_addr[0]),  64'd1);
        check_val("addi.data",  64'(o_data[0]),  64'd5);
        check_val("addi.pc",    64'(o_pc[0]),    64'h8);
        check_val("addi.ts",    64'(o_ts[0]),    64'd3);
        check_val("addi.count", 64'(o_count[0]), 64'd1);

        // $0 writes are never logged
        do_reset();
        for (int k = 0; k < 4; k++) step(1, 0, 32'hDEAD, 32'h40, 0, 0, 0, 0);
        check_val("r0.valid", 64'(o_valid[0]), 64'd0);
        check_val("r0.count", 64'(o_count[0]), 64'd0);
        check_val("r0.drop",  64'(o_drop[0]),  64'd0);

        // Overfill both policies, then push+pop while full, then drain
        do_reset();
        for (int k = 1; k <= 6; k++) step(1, 5'(k), DW'(k), DW'(4 * k), 0, 0, 0, 0);
        check_val("fill.full0", 64'(o_full[0]), 64'd1);
        check_val("fill.drop0", 64'(o_drop[0]), 64'd2);
        check_val("fill.head0", 64'(o_data[0]), 64'd1);
        check_val("fill.full1", 64'(o_full[1]), 64'd1);
        check_val("fill.drop1", 64'(o_drop[1]), 64'd2);
        check_val("fill.head1", 64'(o_data[1]), 64'd3);
        step(1, 3, 7, 32'h100, 0, 0, 0, 1);
        check_val("pp.count0", 64'(o_count[0]), 64'd4);
        check_val("pp.drop0",  64'(o_drop[0]),  64'd2);
        check_val("pp.head0",  64'(o_data[0]),  64'd2);
        check_val("pp.count1", 64'(o_count[1]), 64'd4);
        check_val("pp.drop1",  64'(o_drop[1]),  64'd2);
        check_val("pp.head1",  64'(o_data[1]),  64'd4);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 0, 0, 1);

`ifdef TRACE_MEM_EN
        do_reset();
        step(0, 0, 0, 32'h20, 1, 32'h10, 7, 0);
        check_val("sw.type", 64'(o_type[0]), 64'd1);
        check_val("sw.addr", 64'(o_addr[0]), 64'h10);
        check_val("sw.data", 64'(o_data[0]), 64'd7);
        step(1, 2, 9, 32'h24, 1, 32'h14, 8, 0);
        check_val("coll.drop",  64'(o_drop[0]),  64'd1);
        check_val("coll.count", 64'(o_count[0]), 64'd2);
`endif

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            en = ($urandom_range(0, 9) != 0);
            case ((n / 200) % 3)
                0:       rdy = ($urandom_range(0, 9) < 2);
                1:       rdy = ($urandom_range(0, 9) < 5);
                default: rdy = ($urandom_range(0, 9) < 9);
            endcase
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 $urandom, $urandom,
                 ($urandom_range(0, 3) == 0),
                 $urandom, $urandom, rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/retire_trace_buffer.md
# retire_trace_buffer

Parametrised retirement trace buffer for the single-cycle MIPS core. Each cycle it snoops the core's register write-back port and, optionally, its data-memory write port. Every architecturally visible write is logged with its PC and a cycle timestamp in a circular buffer. A valid/ready drain port lets a bench or debug host read retirements in order without stalling the core. It replaces ad-hoc per-register probing with one ordered event stream.

## Interface
Parameters:
- DATA_W, 32, width of PC, address and data fields
- DEPTH, 16, buffer entries; power of two, ≥2
- MODE, 0, full policy: 0 = drop newest, 1 = overwrite oldest
- TS_W, 16, timestamp counter width

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- en  in  1  capture enable; draining is unaffected
- pc  in  DATA_W  PC of the retiring instruction
- reg_we  in  1  register-file write strobe
- reg_addr  in  5  destination register
- reg_wdata  in  DATA_W  write-back data
- mem_we  in  1  data-memory write strobe (used only with TRACE_MEM_EN)
- mem_addr  in  DATA_W  store address
- mem_wdata  in  DATA_W  store data
- out_valid  out  1  head entry available
- out_ready  in  1  consumer accepts head entry
- out_type  out  1  0 = register write, 1 = memory write
- out_ts  out  TS_W  capture timestamp
- out_pc  out  DATA_W  captured PC
- out_addr  out  DATA_W  register index (zero-extended) or memory address
- out_data  out  DATA_W  written value
- count  out  $clog2(DEPTH)+1  occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- drop_cnt  out  16  lost events, saturating at 16'hFFFF

## Operation
- Event: `en && reg_we && reg_addr != 0`. Writes to register $0 are never logged.
- With TRACE_MEM_EN, a memory event is also `en && mem_we`.
- If a register event and a memory event occur in the same cycle:
  - the register event is pushed;
  - the memory event is discarded and drop_cnt increments.
- Timestamp: free-running TS_W counter; 0 in the first cycle after reset deasserts; increments every cycle regardless of `en`; wraps modulo 2^TS_W. The entry stores the value in its capture cycle.
- Storage: head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; count is held separately.
- Pop: `out_valid && out_ready`; head advances.
- Push when not full: write at tail; tail advances.
- Push and pop in the same cycle, any occupancy including full: both take effect; count unchanged.
- Push when full without a pop:
  - MODE 0: the event is discarded; drop_cnt +1.
  - MODE 1: the oldest entry is overwritten; head and tail both advance; count stays DEPTH; drop_cnt +1.
- When empty, all out_* fields are driven to 0.
- Reset mid-stream: all entries are abandoned; the array contents need not be cleared.

## Timing
- Reset values: out_valid=0, all out_* fields 0, count=0, empty=1, full=0, drop_cnt=0, timestamp=0.
- Event sampled at rising edge N: visible on out_* (out_valid=1) after edge N if it is the new head. Latency is one edge.
- out_* come from registered state only. They have no combinational path from the capture inputs.
- out_ready may depend combinationally on out_valid. out_valid never depends on out_ready.
- Once asserted, out_valid and the head fields stay stable until popped.
  - Exception, MODE 1: an overwrite while full replaces the head in that cycle (the oldest entry is lost).
- count, full, empty and drop_cnt update at the same edge as the push or pop.

## Configuration
- TRACE_MEM_EN defined:
  - mem_we/mem_addr/mem_wdata are captured as out_type=1 entries;
  - same-cycle collision rule as in Operation.
- TRACE_MEM_EN undefined:
  - the memory ports exist but are ignored;
  - out_type is constant 0;
  - no memory collision drops occur.

## Test plan
- Reset, then `addi $1,$0,5` retires at ts 3 with pc 0x8 → next cycle: out_valid=1, type 0, addr 1, data 5, pc 0x8, ts 3; count 1.
- reg_we with reg_addr 0 for 4 cycles → out_valid stays 0, count 0, drop_cnt 0.
- MODE 0, DEPTH 4, out_ready=0, 6 consecutive events with data 1..6 → full=1, drop_cnt=2; draining returns data 1,2,3,4.
- MODE 1, same stimulus → drop_cnt=2; draining returns data 3,4,5,6.
- Full buffer, push and pop in the same cycle → count stays 4, drop_cnt unchanged, order preserved.
- TRACE_MEM_EN, `sw` retires storing 7 to 0x10 → type 1, addr 0x10, data 7. A forced simultaneous reg_we with reg_addr 2 → register entry only, drop_cnt=1.
